arb_requester: RTL and testbench

//   Client-side front end for the N-way round-robin arbiter. Accumulates per-client

---
 rtl/arb_requester_if.sv | 41 ++++
 rtl/arb_requester.sv | 133 +++++++++++++
 tb/tb_arb_requester.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_requester_if.sv
// Handshake bundle between the arbiter front end (master) and its environment (slave).
// Carries the push/full client side and the req/gnt arbiter side plus grant reporting.
interface arb_requester_if #(
   parameter int unsigned N = 4
);
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]  push;
   logic [N-1:0]  full;
   logic [N-1:0]  req;
   logic [N-1:0]  gnt;
   logic          grant_valid;
   logic [IW-1:0] grant_idx;
   logic          overflow;
   logic          spurious;
   logic [N-1:0]  starve;

   modport master (
      input  push,
      input  gnt,
      output full,
      output req,
      output grant_valid,
      output grant_idx,
      output overflow,
      output spurious,
      output starve
   );

   modport slave (
      output push,
      output gnt,
      input  full,
      input  req,
      input  grant_valid,
      input  grant_idx,
      input  overflow,
      input  spurious,
      input  starve
   );
endinterface

// File: rtl/arb_requester.sv
// Client-side token front end for an N-way round-robin arbiter with grant re-emission.
// Per-client starvation monitors are built only when REQ_STARVE_EN is defined.
module arb_requester #(
   parameter int unsigned N     = 4,
   parameter int unsigned DEPTH = 7,
   parameter int unsigned TMO   = 15
) (
   input logic             clk,
   input logic             rst_n,
   arb_requester_if.master bus_io
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   if (N < 1 || DEPTH < 1 || TMO < 1) begin : g_param_chk
      $error("arb_requester: N, DEPTH and TMO must all be at least 1");
   end

   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] cnt_d [N];
   logic [N-1:0]  dec;
   logic [N-1:0]  inc;
   logic [N-1:0]  full;
   logic [N-1:0]  req;
   logic          gnt_legal;
   logic          gv_q, gv_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          ov_q, ov_d;
   logic          sp_q, sp_d;

   assign gnt_legal = $onehot0(bus_io.gnt);

   always_comb begin
      dec   = '0;
      inc   = '0;
      full  = '0;
      req   = '0;
      ov_d  = ov_q;
      sp_d  = sp_q | ~gnt_legal;
      gv_d  = 1'b0;
      idx_d = idx_q;
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = cnt_q[i];
         full[i]  = (cnt_q[i] == CW'(DEPTH));
         dec[i]   = gnt_legal & bus_io.gnt[i] & (cnt_q[i] != '0);
         // A grant frees a slot in the same cycle, so a push to a full client still lands.
         inc[i]   = bus_io.push[i] & (~full[i] | dec[i]);
         // The last token drops req while its grant is present so no stale request is seen.
         req[i]   = dec[i] ? (cnt_q[i] > CW'(1)) : (cnt_q[i] != '0);
         if (gnt_legal && bus_io.gnt[i] && (cnt_q[i] == '0)) begin
            sp_d = 1'b1;
         end
         if (bus_io.push[i] && !inc[i]) begin
            ov_d = 1'b1;
         end
         if (inc[i] && !dec[i]) begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end else if (dec[i] && !inc[i]) begin
            cnt_d[i] = cnt_q[i] - CW'(1);
         end
         if (dec[i]) begin
            gv_d  = 1'b1;
            idx_d = IW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= '0;
         end
         gv_q  <= 1'b0;
         idx_q <= '0;
         ov_q  <= 1'b0;
         sp_q  <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         gv_q  <= gv_d;
         idx_q <= idx_d;
         ov_q  <= ov_d;
         sp_q  <= sp_d;
      end
   end

   assign bus_io.full        = full;
   assign bus_io.req         = req;
   assign bus_io.grant_valid = gv_q;
   assign bus_io.grant_idx   = idx_q;
   assign bus_io.overflow    = ov_q;
   assign bus_io.spurious    = sp_q;

`ifdef REQ_STARVE_EN
   localparam int unsigned WW = $clog2(TMO + 1);

   logic [WW-1:0] wcnt_q [N];
   logic [WW-1:0] wcnt_d [N];
   logic [N-1:0]  starve_q, starve_d;

   always_comb begin
      starve_d = starve_q;
      for (int i = 0; i < N; i++) begin
         wcnt_d[i] = '0;
         if (req[i] && !bus_io.gnt[i]) begin
            wcnt_d[i] = (wcnt_q[i] == WW'(TMO)) ? wcnt_q[i] : wcnt_q[i] + WW'(1);
         end
         if (wcnt_d[i] == WW'(TMO)) begin
            starve_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            wcnt_q[i] <= '0;
         end
         starve_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            wcnt_q[i] <= wcnt_d[i];
         end
         starve_q <= starve_d;
      end
   end

   assign bus_io.starve = starve_q;
`else
   assign bus_io.starve = '0;
`endif
endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: token-count model, compare-every-cycle process,
// a behavioural round-robin arbiter and directed scenarios with literal expectations.
module tb_arb_requester;
   localparam int N     = 4;
   localparam int DEPTH = 7;
   localparam int TMO   = 15;

   logic         clk;
   logic         rst_n;
   logic         arb_en;
   logic         run;
   logic [N-1:0] push_r;
   logic [N-1:0] tb_gnt;
   logic [N-1:0] arb_gnt;

   int errs;
   int checks;

   arb_requester_if #(.N(N)) bus ();

   arb_requester #(
      .N    (N),
      .DEPTH(DEPTH),
      .TMO  (TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus_io(bus)
   );

   assign bus.push = push_r;
   assign bus.gnt  = arb_en ? arb_gnt : tb_gnt;

   always #5 clk = ~clk;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Behavioural round-robin arbiter with a registered one-cycle grant.
   int           ptr;
   int           pidx;
   logic [N-1:0] arb_pick;

   always_comb begin
      arb_pick = '0;
      pidx     = ptr;
      for (int k = 1; k <= N; k++) begin
         if (arb_pick == '0 && bus.req[(ptr + k) % N]) begin
            arb_pick[(ptr + k) % N] = 1'b1;
            pidx = (ptr + k) % N;
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arb_gnt <= '0;
         ptr     <= N - 1;
      end else if (!arb_en) begin
         arb_gnt <= '0;
      end else begin
         arb_gnt <= arb_pick;
         if (arb_pick != '0) ptr <= pidx;
      end
   end

   // Model: token counts per client; a grant is consumed before the push is considered.
   int           m_cnt [N];
   int           n_cnt [N];
   int           m_wait [N];
   int           n_wait [N];
   bit           m_ov, n_ov, m_sp, n_sp, m_gv, n_gv, g_ok;
   int           m_idx, n_idx;
   bit [N-1:0]   m_starve, n_starve, e_req, e_full, e_starve;

   always_comb begin
      n_cnt    = m_cnt;
      n_wait   = m_wait;
      n_ov     = m_ov;
      n_starve = m_starve;
      n_gv     = 1'b0;
      n_idx    = m_idx;
      g_ok     = ($countones(bus.gnt) <= 1);
      n_sp     = m_sp | !g_ok;
      e_req    = '0;
      e_full   = '0;
      for (int i = 0; i < N; i++) begin
         e_full[i] = (m_cnt[i] == DEPTH);
         if (g_ok && bus.gnt[i]) begin
            if (m_cnt[i] == 0) begin
               n_sp = 1'b1;
            end else begin
               n_cnt[i] = m_cnt[i] - 1;
               n_gv     = 1'b1;
               n_idx    = i;
            end
         end
         e_req[i] = (n_cnt[i] > 0);
         if (bus.push[i]) begin
            if (n_cnt[i] < DEPTH) n_cnt[i] = n_cnt[i] + 1;
            else n_ov = 1'b1;
         end
         if (e_req[i] && !bus.gnt[i]) n_wait[i] = (m_wait[i] < TMO) ? m_wait[i] + 1 : TMO;
         else n_wait[i] = 0;
         if (n_wait[i] == TMO) n_starve[i] = 1'b1;
      end
`ifdef REQ_STARVE_EN
      e_starve = m_starve;
`else
      e_starve = '0;
`endif
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_cnt[i]  <= 0;
            m_wait[i] <= 0;
         end
         m_ov     <= 1'b0;
         m_sp     <= 1'b0;
         m_gv     <= 1'b0;
         m_idx    <= 0;
         m_starve <= '0;
      end else begin
         m_cnt    <= n_cnt;
         m_wait   <= n_wait;
         m_ov     <= n_ov;
         m_sp     <= n_sp;
         m_gv     <= n_gv;
         m_idx    <= n_idx;
         m_starve <= n_starve;
      end
   end

   always @(negedge clk) begin
      if (run) begin
         check("req",         32'(bus.req),         32'(e_req));
         check("full",        32'(bus.full),        32'(e_full));
         check("grant_valid", 32'(bus.grant_valid), 32'(m_gv));
         check("grant_idx",   32'(bus.grant_idx),   32'(m_idx));
         check("overflow",    32'(bus.overflow),    32'(m_ov));
         check("spurious",    32'(bus.spurious),    32'(m_sp));
         check("starve",      32'(bus.starve),      32'(e_starve));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      push_r = '0;
      tb_gnt = '0;
      arb_en = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      cyc();
   endtask

   int seq[$];
   int first_c, last_c;

   initial begin
      clk    = 1'b0;
      rst_n  = 1'b1;
      arb_en = 1'b0;
      run    = 1'b0;
      push_r = '0;
      tb_gnt = '0;
      errs   = 0;
      checks = 0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run = 1'b1;
      cyc();
      check("rst_req",    32'(bus.req),         0);
      check("rst_full",   32'(bus.full),        0);
      check("rst_gv",     32'(bus.grant_valid), 0);
      check("rst_idx",    32'(bus.grant_idx),   0);
      check("rst_flags",  32'({bus.overflow, bus.spurious}), 0);
      check("rst_starve", 32'(bus.starve),      0);

      // Single token through the arbiter.
      arb_en = 1'b1;
      push_r = 4'b0100;
      cyc();
      push_r = '0;
      check("t2_req", 32'(bus.req), 32'h4);
      cyc();
      check("t2_gnt", 32'(bus.gnt), 32'h4);
      check("t2_req_drop", 32'(bus.req), 0);
      check("t2_gv_early", 32'(bus.grant_valid), 0);
      cyc();
      check("t2_gv", 32'(bus.grant_valid), 1);
      check("t2_idx", 32'(bus.grant_idx), 2);
      arb_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("t2_no_second", 32'(bus.grant_valid), 0);
         check("t2_idx_hold", 32'(bus.grant_idx), 2);
      end

      // Saturation of client 1, then push+grant while full.
      push_r = 4'b0010;
      repeat (8) cyc();
      push_r = '0;
      check("t3_full", 32'(bus.full), 32'h2);
      check("t3_ovf", 32'(bus.overflow), 1);
      check("t3_req", 32'(bus.req), 32'h2);
      push_r = 4'b0010;
      tb_gnt = 4'b0010;
      check("t3_req_full_gnt", 32'(bus.req), 32'h2);
      cyc();
      push_r = '0;
      tb_gnt = '0;
      check("t3_still_full", 32'(bus.full), 32'h2);
      check("t3_gv", 32'(bus.grant_valid), 1);
      check("t3_idx", 32'(bus.grant_idx), 1);
      check("t3_no_spur", 32'(bus.spurious), 0);

      // Asynchronous reset mid-run with tokens pending.
      push_r = 4'b0001;
      repeat (3) cyc();
      push_r = '0;
      check("t1_req_pre", 32'(bus.req), 32'h3);
      check("t1_full_pre", 32'(bus.full), 32'h2);
      #3 rst_n = 1'b0;
      #1;
      check("t1_req", 32'(bus.req), 0);
      check("t1_full", 32'(bus.full), 0);
      check("t1_ovf", 32'(bus.overflow), 0);
      check("t1_gv", 32'(bus.grant_valid), 0);
      check("t1_spur", 32'(bus.spurious), 0);
      repeat (2) cyc();
      #3 rst_n = 1'b1;
      cyc();
      check("t1_post", 32'({bus.req, bus.full, bus.overflow, bus.spurious, bus.grant_valid}), 0);

      // Two tokens per client with the arbiter running.
      do_reset();
      push_r = 4'b1111;
      repeat (2) cyc();
      push_r = '0;
      arb_en = 1'b1;
      first_c = -1;
      last_c  = -1;
      for (int c = 0; c < 20; c++) begin
         cyc();
         if (bus.grant_valid) begin
            if (seq.size() == 0) first_c = c;
            last_c = c;
            seq.push_back(int'(bus.grant_idx));
         end
      end
      check("t4_count", 32'(seq.size()), 8);
      for (int k = 0; k < seq.size() && k < 8; k++) begin
         check("t4_idx", 32'(seq[k]), 32'(k % 4));
      end
      check("t4_span", 32'(last_c - first_c), 7);
      check("t4_req_end", 32'(bus.req), 0);
      check("t4_gv_end", 32'(bus.grant_valid), 0);

      // Multi-hot grant, then grant to an empty client.
      do_reset();
      push_r = 4'b0101;
      cyc();
      push_r = '0;
      check("t5_spur_pre", 32'(bus.spurious), 0);
      tb_gnt = 4'b0011;
      cyc();
      tb_gnt = '0;
      check("t5_spur_multi", 32'(bus.spurious), 1);
      check("t5_req_multi", 32'(bus.req), 32'h5);
      check("t5_gv_multi", 32'(bus.grant_valid), 0);
      do_reset();
      push_r = 4'b0101;
      cyc();
      push_r = '0;
      tb_gnt = 4'b1000;
      cyc();
      tb_gnt = '0;
      check("t5_spur_empty", 32'(bus.spurious), 1);
      check("t5_req_empty", 32'(bus.req), 32'h5);
      check("t5_gv_empty", 32'(bus.grant_valid), 0);

      // Starvation: one token held with no grants.
      do_reset();
      push_r = 4'b0001;
      cyc();
      push_r = '0;
      repeat (14) cyc();
      check("t6_starve_early", 32'(bus.starve), 0);
      cyc();
`ifdef REQ_STARVE_EN
      check("t6_starve", 32'(bus.starve), 32'h1);
`else
      check("t6_starve", 32'(bus.starve), 0);
`endif
      check("t6_req", 32'(bus.req), 32'h1);
      cyc();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
